// File: rtl/ext_irq_pkg.sv
// Shared constants for the external interrupt controller: register offsets
// within the word-addressed window and the width of a source ID.
package ext_irq_pkg;

  localparam logic [2:0] EIC_PENDING   = 3'd0;
  localparam logic [2:0] EIC_ENABLE    = 3'd1;
  localparam logic [2:0] EIC_EDGE      = 3'd2;
  localparam logic [2:0] EIC_CLAIM     = 3'd3;
  localparam logic [2:0] EIC_COMPLETE  = 3'd4;
  localparam logic [2:0] EIC_INSERVICE = 3'd5;

  // IDs travel in wdata[7:0] for claim/complete and come back in CLAIM reads.
  localparam int EIC_ID_W = 8;
  typedef logic [EIC_ID_W-1:0] eic_id_t;

endpackage

// File: rtl/ext_irq_controller_if.sv
// Register-window bus between the CPU data port / address decoder and the
// interrupt controller. rdata is combinational from the slave side.
interface ext_irq_controller_if #(
  parameter int XLEN = 32
);
  logic            sel;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wenable;
  logic [XLEN-1:0] rdata;

  modport master (output sel, addr, wdata, wenable, input rdata);
  modport slave  (input sel, addr, wdata, wenable, output rdata);
endinterface

// File: rtl/ext_irq_gateway.sv
// Per-source gateway: synchroniser, rising-edge detect, pending latch and
// in-service flag. Claim/complete strobes arrive already validated.
module ext_irq_gateway #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_raw,
  input  logic edge_mode,
  input  logic mode_clear,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   pending_reg;
  logic                   in_service_reg;
  logic                   sync_line;
  logic                   rising;

  assign sync_line  = sync_reg[SYNC_STAGES-1];
  assign rising     = sync_line & ~prev_reg;
  assign pending    = pending_reg;
  assign in_service = in_service_reg;

  // Bring the raw line into clk and keep one cycle of history for edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], irq_raw};
      prev_reg <= sync_line;
    end
  end

  // Pending latch: a claim wins, but an edge landing in the claim cycle is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
    end else if (claim) begin
      pending_reg <= edge_mode & rising;
    end else if (mode_clear) begin
      pending_reg <= 1'b0;
    end else if (edge_mode) begin
      pending_reg <= pending_reg | rising;
    end else begin
      pending_reg <= sync_line & ~in_service_reg;
    end
  end

  // In-service flag set by a claim, cleared by the matching complete.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_service_reg <= 1'b0;
    end else if (claim) begin
      in_service_reg <= 1'b1;
    end else if (complete) begin
      in_service_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/ext_irq_controller.sv
// Machine-external interrupt controller: register window decode, ENABLE/EDGE
// storage, fixed-priority claim selection and the registered mei_pending.
module ext_irq_controller
  import ext_irq_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEI_PORTS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MEI_PORTS-1:0] irq_src,
  ext_irq_controller_if.slave  bus,
  output logic                 mei_pending
);
  logic [2:0]           offset;
  eic_id_t              wr_id;
  eic_id_t              claim_id;
  logic                 enable_wr;
  logic                 edge_wr;
  logic                 claim_wr;
  logic                 complete_wr;
  logic [MEI_PORTS-1:0] enable_reg;
  logic [MEI_PORTS-1:0] edge_reg;
  logic [MEI_PORTS-1:0] enable_next;
  logic [MEI_PORTS-1:0] edge_next;
  logic [MEI_PORTS-1:0] mode_clear;
  logic [MEI_PORTS-1:0] claim_hit;
  logic [MEI_PORTS-1:0] complete_hit;
  logic [MEI_PORTS-1:0] pending;
  logic [MEI_PORTS-1:0] in_service;
  logic [MEI_PORTS-1:0] claimable;
  logic [XLEN-1:0]      rdata_word;
  logic                 mei_pending_reg;
  logic                 unused_bits;

  assign offset      = bus.addr[4:2];
  assign wr_id       = bus.wdata[EIC_ID_W-1:0];
  assign enable_wr   = bus.sel & (offset == EIC_ENABLE);
  assign edge_wr     = bus.sel & (offset == EIC_EDGE);
  assign claim_wr    = bus.sel & bus.wenable[0] & (offset == EIC_CLAIM);
  assign complete_wr = bus.sel & bus.wenable[0] & (offset == EIC_COMPLETE);
  // Only addr[4:2] and the low data bits matter; the rest is deliberately dropped.
  assign unused_bits = ^{bus.addr, bus.wdata, bus.wenable};

  generate
    for (genvar gi = 0; gi < MEI_PORTS; gi++) begin : g_src
      // Bit gi of ENABLE/EDGE lives in byte lane gi/8.
      assign enable_next[gi]  = (enable_wr & bus.wenable[gi/8]) ? bus.wdata[gi] : enable_reg[gi];
      assign edge_next[gi]    = (edge_wr & bus.wenable[gi/8]) ? bus.wdata[gi] : edge_reg[gi];
      assign mode_clear[gi]   = edge_next[gi] != edge_reg[gi];
      // Claim needs the source pending (ENABLE not required); complete needs it in service.
      assign claim_hit[gi]    = claim_wr & (wr_id == eic_id_t'(gi + 1)) & pending[gi];
      assign complete_hit[gi] = complete_wr & (wr_id == eic_id_t'(gi + 1)) & in_service[gi];
      assign claimable[gi]    = pending[gi] & enable_reg[gi] & ~in_service[gi];

      ext_irq_gateway #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_gateway (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_raw   (irq_src[gi]),
        .edge_mode (edge_reg[gi]),
        .mode_clear(mode_clear[gi]),
        .claim     (claim_hit[gi]),
        .complete  (complete_hit[gi]),
        .pending   (pending[gi]),
        .in_service(in_service[gi])
      );
    end
  endgenerate

  // ENABLE and EDGE storage; lane masking is folded into the *_next vectors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable_reg <= '0;
      edge_reg   <= '0;
    end else begin
      enable_reg <= enable_next;
      edge_reg   <= edge_next;
    end
  end

  // Fixed priority: lowest-numbered claimable source wins, reported as index+1.
  always_comb begin
    claim_id = '0;
    for (int i = MEI_PORTS - 1; i >= 0; i--) begin
      if (claimable[i]) begin
        claim_id = eic_id_t'(i + 1);
      end
    end
  end

  // Read mux, combinational from addr; deselected or unmapped offsets read 0.
  always_comb begin
    rdata_word = '0;
    if (bus.sel) begin
      case (offset)
        EIC_PENDING:   rdata_word[MEI_PORTS-1:0] = pending;
        EIC_ENABLE:    rdata_word[MEI_PORTS-1:0] = enable_reg;
        EIC_EDGE:      rdata_word[MEI_PORTS-1:0] = edge_reg;
        EIC_CLAIM:     rdata_word[EIC_ID_W-1:0]  = claim_id;
        EIC_INSERVICE: rdata_word[MEI_PORTS-1:0] = in_service;
        default:       rdata_word = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_word;

  // Request to the CPU, one cycle behind the claimable state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mei_pending_reg <= 1'b0;
    end else begin
      mei_pending_reg <= (claim_id != '0);
    end
  end

  assign mei_pending = mei_pending_reg;

endmodule

// File: tb/tb_ext_irq_controller.sv
// Bench for ext_irq_controller: directed scenarios plus random traffic,
// checked through a read scoreboard fed by a behavioural model.
module tb_ext_irq_controller;
  import ext_irq_pkg::*;

  localparam int XLEN = 32;
  localparam int NP   = 4;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] irq_src = '0;
  logic          mei_pending;
  logic          rd_req = 1'b0;

  ext_irq_controller_if #(.XLEN(XLEN)) bus ();

  ext_irq_controller #(
    .XLEN(XLEN), .MEI_PORTS(NP), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .bus(bus), .mei_pending(mei_pending)
  );

  always #5 clk = ~clk;

  // scoreboard
  string       q_name[$];
  logic [31:0] q_rd[$];
  logic        q_mei[$];
  int          tests = 0;
  int          fails = 0;

  // behavioural model state
  bit            m_pend[NP];
  bit            m_en[NP];
  bit            m_edge[NP];
  bit            m_ins[NP];
  bit            m_mei;
  logic [NP-1:0] hist[0:SYNC];   // hist[k]: irq_src sampled k+1 edges ago

  function automatic int m_claimable();
    for (int i = 0; i < NP; i++)
      if (m_pend[i] && m_en[i] && !m_ins[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input int off);
    logic [31:0] v;
    v = '0;
    case (off)
      0: for (int i = 0; i < NP; i++) v[i] = m_pend[i];
      1: for (int i = 0; i < NP; i++) v[i] = m_en[i];
      2: for (int i = 0; i < NP; i++) v[i] = m_edge[i];
      3: v = 32'(m_claimable());
      5: for (int i = 0; i < NP; i++) v[i] = m_ins[i];
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    int  off, id;
    bit  s, rise, lane, claim, compl, new_edge, nxt_mei;
    off = int'(bus.addr[4:2]);
    id  = int'(bus.wdata[7:0]);
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) begin
        m_pend[i] = 0; m_en[i] = 0; m_edge[i] = 0; m_ins[i] = 0;
      end
      for (int k = 0; k <= SYNC; k++) hist[k] = '0;
      m_mei = 0;
      return;
    end
    nxt_mei = (m_claimable() != 0);
    for (int i = 0; i < NP; i++) begin
      s        = hist[SYNC-1][i];
      rise     = s && !hist[SYNC][i];
      lane     = bus.wenable[i/8];
      claim    = bus.sel && bus.wenable[0] && off == 3 && id == i + 1 && m_pend[i];
      compl    = bus.sel && bus.wenable[0] && off == 4 && id == i + 1 && m_ins[i];
      new_edge = (bus.sel && off == 2 && lane) ? bus.wdata[i] : m_edge[i];
      if (claim) begin
        m_pend[i] = m_edge[i] && rise;
        m_ins[i]  = 1;
      end else begin
        if (new_edge != m_edge[i]) m_pend[i] = 0;
        else if (m_edge[i])        m_pend[i] = m_pend[i] || rise;
        else                       m_pend[i] = s && !m_ins[i];
        if (compl) m_ins[i] = 0;
      end
      if (bus.sel && off == 1 && lane) m_en[i] = bus.wdata[i];
      m_edge[i] = new_edge;
    end
    m_mei = nxt_mei;
    for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = irq_src;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // monitor: each presented read pops one expectation
  initial forever begin
    string       nm;
    logic [31:0] er;
    logic        em;
    @(negedge clk);
    #2;
    if (rd_req) begin
      if (q_rd.size() == 0) begin
        tests++; fails++;
        $display("FAIL scoreboard_empty: read presented with no expectation");
      end else begin
        nm = q_name.pop_front(); er = q_rd.pop_front(); em = q_mei.pop_front();
        tests++;
        if (bus.rdata !== er) begin
          fails++;
          $display("FAIL %s rdata got %h expected %h", nm, bus.rdata, er);
        end
        tests++;
        if (mei_pending !== em) begin
          fails++;
          $display("FAIL %s mei_pending got %b expected %b", nm, mei_pending, em);
        end
        $display("[TB] %s off=%0d rdata=%h mei=%b", nm, bus.addr[4:2], bus.rdata, mei_pending);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.sel = 1'b0; bus.wenable = 4'h0; rd_req = 1'b0;
    end
  endtask

  task automatic drive_addr(input int off);
    logic [31:0] r;
    r = $urandom;
    bus.addr = {r[31:5], 3'(off), r[1:0]};
  endtask

  task automatic wr(input logic s, input int off, input logic [31:0] d, input logic [3:0] we);
    @(negedge clk);
    bus.sel = s; drive_addr(off); bus.wdata = d; bus.wenable = we; rd_req = 1'b0;
  endtask

  // read checked against the model
  task automatic rd(input string nm, input int off, input logic s);
    @(negedge clk);
    bus.sel = s; drive_addr(off); bus.wdata = $urandom; bus.wenable = 4'h0; rd_req = 1'b1;
    q_name.push_back(nm); q_rd.push_back(s ? m_read(off) : 32'h0); q_mei.push_back(m_mei);
  endtask

  // read checked against a hand-derived constant
  task automatic rd_c(input string nm, input int off, input logic [31:0] v, input logic mei);
    @(negedge clk);
    bus.sel = 1'b1; drive_addr(off); bus.wdata = $urandom; bus.wenable = 4'h0; rd_req = 1'b1;
    q_name.push_back(nm); q_rd.push_back(v); q_mei.push_back(mei);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [NP-1:0] flip;
    bus.sel = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wenable = 4'h0;
    idle(3);
    rst_n = 1'b1;

    // 1. reset state
    for (int off = 0; off < 8; off++) rd_c("reset_read", off, 32'h0, 1'b0);

    // 2. level mode on source 0
    wr(1, 1, 32'h1, 4'h1); irq_src[0] = 1'b1;
    idle(6);
    rd_c("lvl_pending", 0, 32'h1, 1'b1);
    rd_c("lvl_claim_id", 3, 32'h1, 1'b1);
    wr(1, 3, 32'h1, 4'h1); idle(1);
    rd_c("lvl_inservice", 5, 32'h1, 1'b0);
    rd_c("lvl_pend_clr", 0, 32'h0, 1'b0);
    wr(1, 4, 32'h1, 4'h1); idle(3);
    rd_c("lvl_repend", 0, 32'h1, 1'b1);
    rd_c("lvl_ins_clr", 5, 32'h0, 1'b1);
    irq_src[0] = 1'b0; idle(4);
    rd("lvl_drop", 0, 1'b1);

    // 3. edge mode on source 2
    wr(1, 2, 32'h4, 4'h1); wr(1, 1, 32'h4, 4'h1);
    idle(1); irq_src[2] = 1'b1; idle(1); irq_src[2] = 1'b0; idle(5);
    rd_c("edge_pending", 0, 32'h4, 1'b1);
    rd_c("edge_claim_id", 3, 32'h3, 1'b1);
    wr(1, 3, 32'h3, 4'h1); idle(1);
    rd_c("edge_ins", 5, 32'h4, 1'b0);
    idle(1); irq_src[2] = 1'b1; idle(1); irq_src[2] = 1'b0; idle(5);
    rd_c("edge_repend", 0, 32'h4, 1'b0);
    wr(1, 4, 32'h3, 4'h1); idle(2);
    rd_c("edge_after_cpl", 3, 32'h3, 1'b1);
    wr(1, 3, 32'h3, 4'h1); wr(1, 4, 32'h3, 4'h1); idle(2);

    // 4. fixed priority and nesting
    wr(1, 2, 32'h0, 4'h1); wr(1, 1, 32'hF, 4'h1);
    irq_src = 4'b1010; idle(6);
    rd_c("prio_2", 3, 32'h2, 1'b1);
    wr(1, 3, 32'h2, 4'h1); idle(2);
    rd_c("prio_4", 3, 32'h4, 1'b1);
    irq_src = 4'b1011; idle(5);
    rd_c("prio_nested", 3, 32'h1, 1'b1);
    rd_c("prio_ins", 5, 32'h2, 1'b1);

    // 5. illegal accesses
    wr(1, 3, 32'h0, 4'h1);  rd("ill_claim0", 5, 1'b1);
    wr(1, 3, 32'h5, 4'h1);  rd("ill_claim5", 5, 1'b1);
    wr(1, 3, 32'h3, 4'h1);  rd("ill_claim_np", 5, 1'b1);
    wr(1, 4, 32'h4, 4'h1);  rd("ill_cpl_nis", 5, 1'b1);
    wr(1, 1, 32'h0, 4'h0);  rd("ill_wen0", 1, 1'b1);
    wr(0, 1, 32'h0, 4'hF);  rd("ill_sel0", 1, 1'b1);
    rd("nosel_read", 3, 1'b0);
    rd_c("ill_enable", 1, 32'hF, 1'b1);
    rd_c("ill_ins", 5, 32'h2, 1'b1);
    wr(1, 4, 32'h2, 4'h1); irq_src = '0; idle(4);

    // 6. edge in the claim cycle, then reset mid-service
    wr(1, 2, 32'h1, 4'h1);
    idle(1); irq_src[0] = 1'b1; idle(1); irq_src[0] = 1'b0; idle(5);
    irq_src[0] = 1'b1; idle(1);
    wr(1, 3, 32'h1, 4'h1); idle(1);
    rd_c("same_cyc_pend", 0, 32'h1, 1'b0);
    rd_c("same_cyc_ins", 5, 32'h1, 1'b0);
    idle(1); rst_n = 1'b0;
    rd_c("rst_ins", 5, 32'h0, 1'b0);
    rd_c("rst_enable", 1, 32'h0, 1'b0);
    rd_c("rst_edge", 2, 32'h0, 1'b0);
    rst_n = 1'b1; idle(5);
    rd_c("rst_relevel", 0, 32'h1, 1'b0);

    // random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      flip = '0;
      for (int b = 0; b < NP; b++) if ($urandom_range(0, 7) == 0) flip[b] = 1'b1;
      r = $urandom_range(0, 99);
      if (r < 40)      rd("rand_rd", $urandom_range(0, 7), ($urandom_range(0, 9) != 0));
      else if (r < 50) wr(1, 1, $urandom, 4'($urandom));
      else if (r < 58) wr(1, 2, $urandom, 4'($urandom));
      else if (r < 72) wr(1, 3, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 6)) : 32'(m_claimable()),
                          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h1);
      else if (r < 86) wr(1, 4, 32'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h1);
      else if (r < 98) wr($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom, 4'($urandom));
      else begin
        idle(1); rst_n = 1'b0; idle(1); rst_n = 1'b1;
      end
      irq_src ^= flip;
    end

    idle(2);
    tests++;
    if (q_rd.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q_rd.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
